inst_axi_bridge: RTL and testbench
==================================

INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

Interface
REQ-001 SHALL have parameter ARID, default 4'h0: constant AXI read ID driven on arid.
REQ-002 SHALL have parameter MAX_OUTST, default 2, legal range 1..3: maximum outstanding AR transactions.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port inst_sram_req, input, 1 bit: fetch request from the fetch stage.
REQ-006 SHALL have port inst_sram_wr, input, 1 bit: write flag, ignored because the block is read-only.
REQ-007 SHALL have port inst_sram_size, input, 2 bits: log2 of the access size in bytes.
REQ-008 SHALL have ports inst_sram_wstrb (input, 4 bits) and inst_sram_wdata (input, 32 bits), both ignored.
REQ-009 SHALL have port inst_sram_addr, input, 32 bits: fetch address.
REQ-010 SHALL have port inst_sram_addr_ok, output, 1 bit: request accepted this cycle.
REQ-011 SHALL have port inst_sram_data_ok, output, 1 bit: instruction returned this cycle.
REQ-012 SHALL have port inst_sram_rdata, output, 32 bits: returned instruction.
REQ-013 SHALL have AR outputs arid (4), araddr (32), arlen (8), arsize (3), arburst (2) and arvalid (1).
REQ-014 SHALL have input arready, 1 bit.
REQ-015 SHALL have R inputs rid (4), rdata (32), rresp (2), rlast (1) and rvalid (1).
REQ-016 SHALL have output rready, 1 bit.

Function
REQ-017 SHALL keep an outstanding counter cnt, width 2, range 0..MAX_OUTST.
- cnt increments on an AR handshake (arvalid&arready).
- cnt decrements on a forwarded R beat.
- cnt is unchanged when both events occur in the same cycle.
REQ-018 SHALL drive arvalid = inst_sram_req & (cnt < MAX_OUTST), combinationally.
REQ-019 SHALL drive araddr = inst_sram_addr, arsize = {1'b0, inst_sram_size}, arlen = 0, arburst = 2'b01, arid = ARID.
REQ-020 SHALL drive inst_sram_addr_ok = arvalid & arready in the same cycle as the request, with zero added latency.
REQ-021 SHALL return responses strictly in request order; rid, rlast and rresp SHALL NOT be checked, and a nonzero rresp still returns rdata.
REQ-022 SHALL drop any R beat that arrives while cnt==0: it is accepted (rready=1) but data_ok stays 0.
REQ-023 SHALL, when cnt==MAX_OUTST, hold arvalid=0 and addr_ok=0 until a beat is forwarded; in that forwarding cycle a new AR MAY issue.
REQ-024 SHALL never assert addr_ok while inst_sram_req=0.
REQ-025 SHALL ignore inst_sram_wr=1 and treat the access as a read.

Reset
REQ-026 SHALL, while reset=1, clear cnt to 0 and drive arvalid=0, inst_sram_addr_ok=0, inst_sram_data_ok=0 and inst_sram_rdata=0.
REQ-027 SHALL drive rready=1 during reset.
REQ-028 SHALL discard any transaction in flight when reset is asserted; beats for those transactions arriving afterwards fall under REQ-022.

Configuration
REQ-029 SHALL use macro IBRIDGE_RBUF_EN to select how R beats are forwarded.
REQ-030 SHALL, with IBRIDGE_RBUF_EN undefined:
- drive rready=1 constantly;
- drive data_ok = rvalid & (cnt!=0);
- drive inst_sram_rdata = rdata combinationally (zero-cycle latency).
REQ-031 SHALL, with IBRIDGE_RBUF_EN defined:
- capture each valid beat into a 1-entry register buf/buf_valid;
- assert data_ok from buf_valid one cycle after the R handshake, with inst_sram_rdata = buf;
- drive rready = ~buf_valid | data_ok, so back-to-back beats are accepted with no bubble;
- decrement cnt when data_ok asserts;
- clear buf_valid on reset.

Verification
REQ-032 SHALL cover single fetch: req with addr 0x1c000000 and arready=1 in the same cycle -> addr_ok=1 that cycle and araddr=0x1c000000; rvalid with rdata=0x02800c0c two cycles later -> data_ok=1 and rdata=0x02800c0c in that cycle (one cycle later with IBRIDGE_RBUF_EN).
REQ-033 SHALL cover the outstanding limit: three consecutive requests with arready=1 and no R -> addr_ok=1,1,0 and cnt=2; the first R beat -> third addr_ok in the same cycle.
REQ-034 SHALL cover AR backpressure: req held with arready=0 for 3 cycles -> addr_ok=0 for 3 cycles; arready=1 on cycle 4 -> addr_ok=1 and cnt=1.
REQ-035 SHALL cover ordering: addresses 0x1c000000 and 0x1c000004 issued, beats A then B -> data_ok pulses return A then B, and cnt returns to 0.
REQ-036 SHALL cover reset mid-flight: one AR outstanding, reset for 1 cycle, then rvalid=1 -> data_ok stays 0 and cnt=0.
REQ-037 SHALL cover a response error: rresp=2'b10 with rdata=0xdeadbeef -> data_ok=1 and rdata=0xdeadbeef.

Source files
------------

// File: rtl/inst_axi_bridge.sv
// -----------------------------------------------------------------------------
// inst_axi_bridge
//
// Purpose
//   Bridges a read-only SRAM-style instruction fetch port onto the AXI AR/R
//   channels. Each accepted fetch becomes a single-beat AXI read (arlen=0,
//   INCR burst, constant arid). Up to MAX_OUTST reads may be in flight.
//   Read data returns to the fetch stage strictly in request order. The bridge
//   relies on the slave returning beats in order, so rid, rlast and rresp are
//   not inspected. A beat that arrives while nothing is outstanding is
//   accepted and then dropped. This covers stale beats from reads that a
//   reset abandoned.
//
// Build option
//   IBRIDGE_RBUF_EN : when defined, each R beat is captured in a one-entry
//                     register and presented to the fetch stage one cycle
//                     later. This breaks the rvalid/rdata -> data_ok/rdata
//                     combinational path. When undefined (default), R beats
//                     pass through with zero latency and rready is tied high.
//
// Parameters
//   ARID      : constant AXI read ID driven on arid.
//   MAX_OUTST : maximum number of outstanding AR transactions (1..3).
//
// Ports
//   clk                 in   clock; all state changes on its rising edge
//   reset               in   synchronous active-high reset
//   inst_sram_req       in   fetch request
//   inst_sram_wr        in   write flag (ignored, the port is read-only)
//   inst_sram_size[1:0] in   log2 of the access size in bytes
//   inst_sram_wstrb[3:0]in   ignored
//   inst_sram_addr[31:0]in   fetch address
//   inst_sram_wdata[31:0]in  ignored
//   inst_sram_addr_ok   out  request accepted this cycle
//   inst_sram_data_ok   out  instruction returned this cycle
//   inst_sram_rdata[31:0]out returned instruction
//   arid/araddr/arlen/arsize/arburst/arvalid  out  AXI read address channel
//   arready             in   AXI read address ready
//   rid/rdata/rresp/rlast/rvalid              in   AXI read data channel
//   rready              out  AXI read data ready
// -----------------------------------------------------------------------------
module inst_axi_bridge #(
    parameter logic [3:0] ARID      = 4'h0,
    parameter int         MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,

    // SRAM-style fetch port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

    // Number of AR handshakes whose data has not yet reached the fetch stage.
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;

    logic       w_room;      // a new AR may issue this cycle
    logic       w_ar_hs;     // AR handshake this cycle
    logic       w_fwd;       // a beat is handed to the fetch stage this cycle

    // Inputs that a read-only bridge has no use for.
    logic       w_unused_inputs;
    assign w_unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                               rid, rresp, rlast};

    // ------------------------------------------------------------------
    // AR channel
    // ------------------------------------------------------------------
    // When the counter is full, a beat forwarded in the same cycle frees a
    // slot. The new AR may then issue in that cycle without a bubble.
    // Because the counter is unchanged on simultaneous inc/dec, it never
    // exceeds MAX_OUTST.
    assign w_room  = (r_cnt < MAX_CNT) | w_fwd;
    assign arvalid = ~reset & inst_sram_req & w_room;
    assign w_ar_hs = arvalid & arready;

    // addr_ok is the AR handshake itself. It adds no latency, so the fetch
    // stage sees acceptance in the cycle it presents the request.
    assign inst_sram_addr_ok = w_ar_hs;

    assign arid    = ARID;
    assign araddr  = inst_sram_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, inst_sram_size};
    assign arburst = 2'b01;

    // ------------------------------------------------------------------
    // R channel
    // ------------------------------------------------------------------
`ifdef IBRIDGE_RBUF_EN
    logic [31:0] r_buf;
    logic        r_buf_valid;
    logic        w_r_hs;
    logic        w_capture;

    assign inst_sram_data_ok = ~reset & r_buf_valid;
    assign inst_sram_rdata   = reset ? 32'd0 : r_buf;
    assign w_fwd             = inst_sram_data_ok;

    // The buffer drains in the same cycle that it presents its data. A new
    // beat can therefore be taken while the buffer empties.
    assign rready = reset | ~r_buf_valid | inst_sram_data_ok;
    assign w_r_hs = rvalid & rready;

    // A beat sitting in the buffer is still counted in r_cnt. The number of
    // beats still expected on the bus is r_cnt - r_buf_valid. Anything
    // beyond that is a stale beat and is dropped.
    assign w_capture = w_r_hs & (r_cnt > {1'b0, r_buf_valid});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf       <= 32'd0;
        end else if (w_capture) begin
            r_buf_valid <= 1'b1;
            r_buf       <= rdata;
        end else if (inst_sram_data_ok) begin
            r_buf_valid <= 1'b0;
        end
    end
`else
    // Pass-through: beats go straight to the fetch stage. A beat that
    // arrives with nothing outstanding is still accepted, but data_ok is
    // not raised for it.
    assign rready            = 1'b1;
    assign inst_sram_data_ok = ~reset & rvalid & (r_cnt != 2'd0);
    assign inst_sram_rdata   = reset ? 32'd0 : rdata;
    assign w_fwd             = inst_sram_data_ok;
`endif

    // ------------------------------------------------------------------
    // Outstanding counter
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_ar_hs, w_fwd})
            2'b10:   w_cnt_next = r_cnt + 2'd1;
            2'b01:   w_cnt_next = r_cnt - 2'd1;
            default: w_cnt_next = r_cnt;
        endcase
    end

    // Reset drops every in-flight transaction. Beats for those reads that
    // arrive later find r_cnt==0 and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 2'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_axi_bridge
//
// Bench for inst_axi_bridge in its default pass-through build. The reference
// model is a queue of outstanding fetch addresses. A request is accepted
// while the queue holds fewer than MAX_OUTST entries, or when a beat retires
// the oldest entry in the same cycle. A beat retires the oldest entry only if
// the queue is non-empty. The slave returns data derived from the address.
// -----------------------------------------------------------------------------
module tb_inst_axi_bridge;

    localparam int MAX_OUTST = 2;

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q[$];   // outstanding fetch addresses, oldest first

    inst_axi_bridge #(.ARID(4'h0), .MAX_OUTST(MAX_OUTST)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // Apply inputs (called just after a rising edge) and move to the
    // sampling point on the falling edge.
    task automatic drive(input logic req, input logic [31:0] addr, input logic ar_rdy,
                         input logic rv, input logic [31:0] rd, input logic [1:0] rr);
        inst_sram_req   = req;
        inst_sram_addr  = addr;
        inst_sram_size  = 2'd2;
        inst_sram_wr    = 1'($urandom);
        inst_sram_wstrb = 4'($urandom);
        inst_sram_wdata = $urandom;
        arready         = ar_rdy;
        rvalid          = rv;
        rdata           = rd;
        rresp           = rr;
        rid             = 4'($urandom);
        rlast           = 1'($urandom);
        @(negedge clk);
    endtask

    // Advance through the rising edge and update the reference model.
    task automatic tick();
        logic fwd;
        logic acc;
        fwd = !reset && rvalid && (q.size() != 0);
        acc = !reset && inst_sram_req && arready && ((q.size() < MAX_OUTST) || fwd);
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (fwd) begin
                $display("txn R  addr=%08h data=%08h", q[0], rdata);
                void'(q.pop_front());
            end
            if (acc) begin
                $display("txn AR addr=%08h", inst_sram_addr);
                q.push_back(inst_sram_addr);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'h1c00_0000, 1'b1, 1'b1, 32'h1234_5678, 2'b00);
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
        checks++; if (inst_sram_addr_ok !== 1'b0) begin failures++; $display("FAIL reset_addr_ok got=%b exp=0", inst_sram_addr_ok); end
        checks++; if (inst_sram_data_ok !== 1'b0) begin failures++; $display("FAIL reset_data_ok got=%b exp=0", inst_sram_data_ok); end
        checks++; if (inst_sram_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%08h exp=00000000", inst_sram_rdata); end
        checks++; if (rready !== 1'b1) begin failures++; $display("FAIL reset_rready got=%b exp=1", rready); end
        tick();
        tick();
        reset = 1'b0;
        checks++; if (dut.r_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", dut.r_cnt); end
    endtask

    task automatic test_single_fetch();
        drive(1'b1, 32'h1c00_0000, 1'b1, 1'b0, 32'd0, 2'b00);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL single_addr_ok got=%b exp=1", inst_sram_addr_ok); end
        checks++; if (araddr !== 32'h1c00_0000) begin failures++; $display("FAIL single_araddr got=%08h exp=1c000000", araddr); end
        checks++; if ({arid, arlen, arsize, arburst} !== {4'h0, 8'd0, 3'd2, 2'b01}) begin
            failures++; $display("FAIL single_ar_fields got id=%h len=%h size=%h burst=%b exp 0/00/2/01", arid, arlen, arsize, arburst); end
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
        checks++; if (inst_sram_data_ok !== 1'b0) begin failures++; $display("FAIL single_idle_data_ok got=%b exp=0", inst_sram_data_ok); end
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0280_0c0c, 2'b00);
        checks++; if (inst_sram_data_ok !== 1'b1) begin failures++; $display("FAIL single_data_ok got=%b exp=1", inst_sram_data_ok); end
        checks++; if (inst_sram_rdata !== 32'h0280_0c0c) begin failures++; $display("FAIL single_rdata got=%08h exp=02800c0c", inst_sram_rdata); end
        tick();
        checks++; if (dut.r_cnt !== 2'd0) begin failures++; $display("FAIL single_cnt got=%0d exp=0", dut.r_cnt); end
    endtask

    task automatic test_outstanding_limit();
        logic [2:0] exp_ok;
        exp_ok = 3'b011;   // bit i: expected addr_ok of request i
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1c00_0100 + 32'(i*4), 1'b1, 1'b0, 32'd0, 2'b00);
            checks++; if (inst_sram_addr_ok !== exp_ok[i]) begin failures++; $display("FAIL limit_addr_ok%0d got=%b exp=%b", i, inst_sram_addr_ok, exp_ok[i]); end
            tick();
        end
        checks++; if (dut.r_cnt !== 2'd2) begin failures++; $display("FAIL limit_cnt got=%0d exp=2", dut.r_cnt); end
        drive(1'b1, 32'h1c00_0108, 1'b1, 1'b1, mem_word(32'h1c00_0100), 2'b00);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL limit_third_addr_ok got=%b exp=1", inst_sram_addr_ok); end
        checks++; if (inst_sram_data_ok !== 1'b1) begin failures++; $display("FAIL limit_first_data_ok got=%b exp=1", inst_sram_data_ok); end
        tick();
        checks++; if (dut.r_cnt !== 2'd2) begin failures++; $display("FAIL limit_cnt_after got=%0d exp=2", dut.r_cnt); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'd0, 1'b0, 1'b1, mem_word(q[0]), 2'b00);
            tick();
        end
        checks++; if (dut.r_cnt !== 2'd0) begin failures++; $display("FAIL limit_drain_cnt got=%0d exp=0", dut.r_cnt); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1c00_0200, 1'b0, 1'b0, 32'd0, 2'b00);
            checks++; if ({arvalid, inst_sram_addr_ok} !== 2'b10) begin failures++; $display("FAIL bp_wait%0d got arvalid=%b addr_ok=%b exp 1/0", i, arvalid, inst_sram_addr_ok); end
            tick();
        end
        drive(1'b1, 32'h1c00_0200, 1'b1, 1'b0, 32'd0, 2'b00);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b exp=1", inst_sram_addr_ok); end
        tick();
        checks++; if (dut.r_cnt !== 2'd1) begin failures++; $display("FAIL bp_cnt got=%0d exp=1", dut.r_cnt); end
        drive(1'b0, 32'd0, 1'b0, 1'b1, mem_word(32'h1c00_0200), 2'b00);
        tick();
    endtask

    task automatic test_ordering();
        drive(1'b1, 32'h1c00_0000, 1'b1, 1'b0, 32'd0, 2'b00); tick();
        drive(1'b1, 32'h1c00_0004, 1'b1, 1'b0, 32'd0, 2'b00); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hAAAA_0001, 2'b00);
        checks++; if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'hAAAA_0001}) begin failures++; $display("FAIL order_A got ok=%b data=%08h exp 1/aaaa0001", inst_sram_data_ok, inst_sram_rdata); end
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hBBBB_0002, 2'b00);
        checks++; if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'hBBBB_0002}) begin failures++; $display("FAIL order_B got ok=%b data=%08h exp 1/bbbb0002", inst_sram_data_ok, inst_sram_rdata); end
        tick();
        checks++; if (dut.r_cnt !== 2'd0) begin failures++; $display("FAIL order_cnt got=%0d exp=0", dut.r_cnt); end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 32'h1c00_0300, 1'b1, 1'b0, 32'd0, 2'b00); tick();
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00); tick();
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h1111_2222, 2'b00);
        checks++; if (inst_sram_data_ok !== 1'b0) begin failures++; $display("FAIL midreset_data_ok got=%b exp=0", inst_sram_data_ok); end
        checks++; if (rready !== 1'b1) begin failures++; $display("FAIL midreset_rready got=%b exp=1", rready); end
        tick();
        checks++; if (dut.r_cnt !== 2'd0) begin failures++; $display("FAIL midreset_cnt got=%0d exp=0", dut.r_cnt); end
    endtask

    task automatic test_rresp_error();
        drive(1'b1, 32'h1c00_0400, 1'b1, 1'b0, 32'd0, 2'b00); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hdead_beef, 2'b10);
        checks++; if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'hdead_beef}) begin failures++; $display("FAIL rresp_err got ok=%b data=%08h exp 1/deadbeef", inst_sram_data_ok, inst_sram_rdata); end
        tick();
    endtask

    task automatic test_random();
        logic        req, ardy, rv, fwd, exp_arvalid, exp_ok;
        logic [31:0] addr, rd, exp_rdata;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            req   = 1'($urandom);
            ardy  = ($urandom_range(0, 3) != 0);
            rv    = ($urandom_range(0, 2) == 0);
            addr  = {$urandom_range(0, 255), 2'b00} + 32'h1c00_0000;
            rd    = (q.size() != 0) ? mem_word(q[0]) : $urandom;
            fwd         = !reset && rv && (q.size() != 0);
            exp_arvalid = !reset && req && ((q.size() < MAX_OUTST) || fwd);
            exp_ok      = exp_arvalid && ardy;
            exp_rdata   = reset ? 32'd0 : rd;
            drive(req, addr, ardy, rv, rd, 2'($urandom));
            checks++; if (arvalid !== exp_arvalid) begin failures++; $display("FAIL rand_arvalid n=%0d got=%b exp=%b", n, arvalid, exp_arvalid); end
            checks++; if (inst_sram_addr_ok !== exp_ok) begin failures++; $display("FAIL rand_addr_ok n=%0d got=%b exp=%b", n, inst_sram_addr_ok, exp_ok); end
            checks++; if (inst_sram_data_ok !== fwd) begin failures++; $display("FAIL rand_data_ok n=%0d got=%b exp=%b", n, inst_sram_data_ok, fwd); end
            if (fwd || reset) begin
                checks++; if (inst_sram_rdata !== exp_rdata) begin failures++; $display("FAIL rand_rdata n=%0d got=%08h exp=%08h", n, inst_sram_rdata, exp_rdata); end
            end
            if (exp_arvalid) begin
                checks++; if (araddr !== addr) begin failures++; $display("FAIL rand_araddr n=%0d got=%08h exp=%08h", n, araddr, addr); end
            end
            tick();
            checks++; if (32'(dut.r_cnt) !== q.size()) begin failures++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, dut.r_cnt, q.size()); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
        tick();
        test_reset();
        test_single_fetch();
        test_outstanding_limit();
        test_backpressure();
        test_ordering();
        test_reset_midflight();
        test_rresp_error();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
